// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS-subset control FSM with memory-wait timeout and retired-instruction counter
module multi_cycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             reg_write_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [3:0]       alu_op_o,
  output logic [1:0]       pc_src_o,
  output logic [2:0]       state_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             err_o,
  output logic [1:0]       err_code_o
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_t;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  state_t           state, state_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic [1:0]       err_code, err_code_n;
  logic [CNT_W-1:0] instret;
  logic is_r, is_jr, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, is_jal, legal, mem_wait, tmo;
  assign is_r     = opcode_i == 6'b000000;
  assign is_jr    = is_r && funct_i == 6'b001000;
  assign is_lw    = opcode_i == 6'b100011;
  assign is_sw    = opcode_i == 6'b101011;
  assign is_beq   = opcode_i == 6'b000100;
  assign is_bne   = opcode_i == 6'b000101;
  assign is_addi  = opcode_i == 6'b001000;
  assign is_j     = opcode_i == 6'b000010;
  assign is_jal   = opcode_i == 6'b000011;
  assign legal    = is_r | is_lw | is_sw | is_beq | is_bne | is_addi | is_j | is_jal;
  assign mem_wait = (state == FETCH || state == MEM) && !mem_ready_i;
  // the wait counter holds the number of stalled cycles already spent, so this is the last allowed one
  assign tmo      = (TIMEOUT > 0) && mem_wait && (wcnt == WW'(TIMEOUT - 1));
  assign state_o    = state;
  assign err_o      = state == TRAP;
  assign err_code_o = err_code;
  assign instret_o  = instret;
  // next-state and control decode; everything not driven by the current step stays 0
  always_comb begin
    state_n      = state;
    err_code_n   = err_code;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 2'd0;
    mem_to_reg_o = 2'd0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 4'b0000;
    pc_src_o     = 2'd0;
    retire_o     = 1'b0;
    case (state)
      FETCH: begin
        mem_req_o = 1'b1;
        alu_op_o  = 4'b0010;
        if (tmo) begin
          state_n    = TRAP;
          err_code_n = 2'd2;
        end else if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_n    = DECODE;
        end
      end
      DECODE: begin
        if (!legal) begin
          state_n    = TRAP;
          err_code_n = 2'd1;
        end else if (is_j || is_jal || is_jr) begin
          pc_write_o   = 1'b1;
          pc_src_o     = is_jr ? 2'd3 : 2'd2;
          reg_write_o  = is_jal;
          reg_dst_o    = is_jal ? 2'd2 : 2'd0;
          mem_to_reg_o = is_jal ? 2'd2 : 2'd0;
          retire_o     = 1'b1;
          state_n      = FETCH;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        alu_op_o    = is_r ? 4'b1111 : (is_beq || is_bne) ? 4'b0110 : 4'b0010;
        alu_src_b_o = (is_lw || is_sw) ? 2'd1 : 2'd0;
        if (is_beq || is_bne) begin
          pc_src_o   = 2'd1;
          pc_write_o = is_beq ? zero_i : !zero_i;
          retire_o   = 1'b1;
          state_n    = FETCH;
        end else begin
          state_n = (is_lw || is_sw) ? MEM : WB;
        end
      end
      MEM: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = is_sw;
        if (tmo) begin
          state_n    = TRAP;
          err_code_n = 2'd2;
        end else if (mem_ready_i) begin
          retire_o = is_sw;
          state_n  = is_sw ? FETCH : WB;
        end
      end
      WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = is_r ? 2'd1 : 2'd0;
        mem_to_reg_o = is_lw ? 2'd1 : 2'd0;
        retire_o     = 1'b1;
        state_n      = FETCH;
      end
      TRAP: ;
      default: state_n = FETCH;
    endcase
    wcnt_n = (state_n == state && mem_wait) ? wcnt + 1'b1 : '0;
  end
  // state, wait counter, error code and retired-instruction count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= FETCH;
      wcnt     <= '0;
      err_code <= 2'd0;
      instret  <= '0;
    end else begin
      state    <= state_n;
      wcnt     <= wcnt_n;
      err_code <= err_code_n;
      if (retire_o) instret <= instret + 1'b1;
    end
  end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum memory-wait cycles; 0 disables the timeout.
REQ-003 SHALL have ports: clk_i in 1 clock; rst_i in 1 asynchronous active-low reset.
REQ-004 SHALL have ports: opcode_i in 6 IR[31:26]; funct_i in 6 IR[5:0]; zero_i in 1 ALU zero; mem_ready_i in 1 memory access complete.
REQ-005 SHALL have ports: pc_write_o out 1; ir_write_o out 1; mem_req_o out 1; mem_we_o out 1; iord_o out 1 (0 = PC address, 1 = ALU address).
REQ-006 SHALL have ports: reg_write_o out 1; reg_dst_o out 2 (0 = rt, 1 = rd, 2 = $31); mem_to_reg_o out 2 (0 = ALU, 1 = memory, 2 = PC).
REQ-007 SHALL have ports: alu_src_a_o out 1; alu_src_b_o out 2; alu_op_o out 4; pc_src_o out 2 (0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs).
REQ-008 SHALL have ports: state_o out 3; retire_o out 1; instret_o out CNT_W; err_o out 1; err_code_o out 2.

Function
REQ-009 SHALL implement state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-010 SHALL decode: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010, jal 000011, and jr as R-type with funct 001000; every other opcode is illegal.
REQ-011 SHALL generate all control outputs combinationally from the current state, opcode_i, funct_i, zero_i and mem_ready_i; unlisted outputs are 0.
REQ-012 FETCH: mem_req_o=1, iord_o=0; hold while mem_ready_i=0; on mem_ready_i=1 assert ir_write_o=1, pc_write_o=1, pc_src_o=0, then go to DECODE.
REQ-013 DECODE: illegal opcode -> TRAP with err_code_o=1.
REQ-014 DECODE: j -> pc_write_o=1, pc_src_o=2, then FETCH.
REQ-015 DECODE: jal -> pc_write_o=1, pc_src_o=2, reg_write_o=1, reg_dst_o=2, mem_to_reg_o=2, then FETCH.
REQ-016 DECODE: jr -> pc_write_o=1, pc_src_o=3, then FETCH.
REQ-017 DECODE: all other legal instructions -> EXEC.
REQ-018 EXEC: R-type and addi -> WB.
REQ-019 EXEC: lw and sw -> MEM, with alu_src_b_o=1 (immediate).
REQ-020 EXEC: beq -> pc_write_o=zero_i; bne -> pc_write_o=~zero_i; both with pc_src_o=1, then FETCH.
REQ-021 MEM: mem_req_o=1, iord_o=1, mem_we_o=1 for sw only; hold while mem_ready_i=0; on ready, lw -> WB and sw -> FETCH.
REQ-022 WB: reg_write_o=1; reg_dst_o=1 and mem_to_reg_o=0 for R-type; reg_dst_o=0 for addi and lw; mem_to_reg_o=1 for lw; then FETCH.
REQ-023 alu_op_o SHALL be 0010 (add) for lw, sw, addi and PC increment, 0110 (sub) for beq/bne, and 1111 for R-type (ALU_Ctrl uses funct).
REQ-024 Wait counter: counts cycles in FETCH/MEM with mem_ready_i=0 and clears on state change; when TIMEOUT>0 and count reaches TIMEOUT-1 with mem_ready_i still 0 -> TRAP, err_code_o=2.
REQ-025 retire_o SHALL pulse 1 cycle on the final cycle of each instruction: DECODE for j/jal/jr, EXEC for branches, MEM for sw, WB otherwise.
REQ-026 instret_o SHALL increment on each retire_o and wrap from 2^CNT_W-1 to 0.
REQ-027 TRAP is sticky until reset: err_o=1, all write/request outputs 0, instret_o frozen.
REQ-028 state_o SHALL equal the current state encoding.

Reset
REQ-029 rst_i=0 SHALL immediately force state FETCH, wait counter 0, instret_o 0, err_o 0 and err_code_o 0, including mid-instruction and from TRAP.
REQ-030 After rst_i deasserts, the first FETCH SHALL begin on the next rising edge.

Verification
REQ-031 add R-type, mem_ready_i always 1 -> states 0,1,2,4; reg_write_o=1 in WB; instret_o=1.
REQ-032 lw with mem_ready_i low 3 cycles in MEM -> MEM held 4 cycles, mem_to_reg_o=1 in WB; sw retires in MEM, mem_we_o=1.
REQ-033 beq zero_i=0 -> pc_write_o=0; bne zero_i=0 -> pc_write_o=1, pc_src_o=1; each retires in EXEC.
REQ-034 jal -> DECODE has pc_src_o=2, reg_dst_o=2, mem_to_reg_o=2; jr -> pc_src_o=3.
REQ-035 opcode 111111 -> TRAP, err_code_o=1; TIMEOUT=4 with mem_ready_i held 0 in FETCH -> TRAP after 4 cycles, err_code_o=2.
REQ-036 CNT_W=4 with 17 retirements -> instret_o=1; rst_i low mid-MEM -> state_o=0 and instret_o=0 asynchronously.
